// File: rtl/velocity_update_pkg.sv
// -----------------------------------------------------------------------------
// velocity_update_pkg
// Shared definitions for the velocity update sequencer:
//   COMP_W / DATA_W   : signed Q16.16 component width and packed {z,y,x} width
//   DT_M_DEFAULT      : default dt/m constant (Q16.16)
//   DT_SHIFT_DEFAULT  : default right arithmetic shift applied to each product
//   vu_state_e        : sequencer FSM state encoding
// Optional feature macro used by the block: VELOCITY_SAT_EN.
// -----------------------------------------------------------------------------
package velocity_update_pkg;

    localparam int COMP_W = 32;
    localparam int DATA_W = 3 * COMP_W;

    localparam logic signed [31:0] DT_M_DEFAULT     = 32'sh0000_8000;
    localparam int                 DT_SHIFT_DEFAULT = 16;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_CNT   = 4'd1,
        WAIT_CNT = 4'd2,
        RD_VEL   = 4'd3,
        WAIT_VEL = 4'd4,
        WAIT_F   = 4'd5,
        COMPUTE  = 4'd6,
        WRITE    = 4'd7,
        DONE     = 4'd8
    } vu_state_e;

endpackage

// File: rtl/velocity_axis_update.sv
// -----------------------------------------------------------------------------
// velocity_axis_update
// Purely combinational single-component velocity update:
//   v_o = v_i + truncate((f_i * DT_M) >>> DT_SHIFT)
// Ports:
//   v_i  in  COMP_WIDTH  current velocity component (signed Q16.16)
//   f_i  in  COMP_WIDTH  accumulated force component (signed Q16.16)
//   v_o  out COMP_WIDTH  updated velocity component
// Macro VELOCITY_SAT_EN: when defined the sum saturates to the signed range,
// otherwise it wraps modulo 2^COMP_WIDTH.
// -----------------------------------------------------------------------------
module velocity_axis_update
    import velocity_update_pkg::*;
#(
    parameter int                            COMP_WIDTH = COMP_W,
    parameter logic signed [COMP_WIDTH-1:0]  DT_M       = DT_M_DEFAULT,
    parameter int                            DT_SHIFT   = DT_SHIFT_DEFAULT
) (
    input  logic signed [COMP_WIDTH-1:0] v_i,
    input  logic signed [COMP_WIDTH-1:0] f_i,
    output logic signed [COMP_WIDTH-1:0] v_o
);

`ifdef VELOCITY_SAT_EN
    localparam logic signed [COMP_WIDTH-1:0] SAT_MAX = {1'b0, {(COMP_WIDTH-1){1'b1}}};
    localparam logic signed [COMP_WIDTH-1:0] SAT_MIN = {1'b1, {(COMP_WIDTH-1){1'b0}}};

    // One guard bit is enough: the sum of two W-bit signed values fits in W+1.
    function automatic logic signed [COMP_WIDTH-1:0] sat_add(
        input logic signed [COMP_WIDTH-1:0] a,
        input logic signed [COMP_WIDTH-1:0] b
    );
        logic signed [COMP_WIDTH:0] s;
        s = {a[COMP_WIDTH-1], a} + {b[COMP_WIDTH-1], b};
        if (s[COMP_WIDTH] != s[COMP_WIDTH-1]) begin
            sat_add = s[COMP_WIDTH] ? SAT_MIN : SAT_MAX;
        end else begin
            sat_add = s[COMP_WIDTH-1:0];
        end
    endfunction
`endif

    logic signed [2*COMP_WIDTH-1:0] prod;
    logic signed [COMP_WIDTH-1:0]   scaled;

    always_comb begin
        // Both operands are sign-extended to the full product width first.
        prod   = (2*COMP_WIDTH)'(f_i) * (2*COMP_WIDTH)'(DT_M);
        scaled = COMP_WIDTH'(prod >>> DT_SHIFT);
`ifdef VELOCITY_SAT_EN
        v_o    = sat_add(v_i, scaled);
`else
        v_o    = v_i + scaled;
`endif
    end

endmodule

// File: rtl/velocity_update_ctrl.sv
// -----------------------------------------------------------------------------
// velocity_update_ctrl
// Per-cell motion-update sequencer driving the single port of the cell's
// velocity memory. One pass: read the particle count at address 0, then for
// each particle 1..count read {vz,vy,vx}, accept its force word over
// force_valid/force_ready, compute v' = v + ((f*DT_M) >>> DT_SHIFT) per
// component and write v' back to the same address.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse, begins a pass (ignored unless IDLE)
//   force_valid/_ready/_data   force word handshake, {fz,fy,fx}
//   mem_address/_data/_rden/_wren, mem_q   velocity memory port
//                   (mem_q valid one cycle after mem_rden)
//   busy            high in every state except IDLE
//   done            one-cycle pulse at the end of a pass
//   particle_count  count latched from address 0, clamped to PARTICLE_NUM-1
// Macro VELOCITY_SAT_EN: saturating component sums (default build wraps).
// -----------------------------------------------------------------------------
module velocity_update_ctrl
    import velocity_update_pkg::*;
#(
    parameter int                           DATA_WIDTH   = DATA_W,
    parameter int                           COMP_WIDTH   = COMP_W,
    parameter int                           ADDR_WIDTH   = 8,
    parameter int                           PARTICLE_NUM = 220,
    parameter logic signed [COMP_WIDTH-1:0] DT_M         = DT_M_DEFAULT,
    parameter int                           DT_SHIFT     = DT_SHIFT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  force_valid,
    output logic                  force_ready,
    input  logic [DATA_WIDTH-1:0] force_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] particle_count
);

    localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);

    vu_state_e             state_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] vel_q;
    logic [DATA_WIDTH-1:0] force_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic                  mem_rden_q;
    logic                  mem_wren_q;
    logic                  force_ready_q;
    logic                  busy_q;
    logic                  done_q;

    logic [ADDR_WIDTH-1:0] count_d;
    logic [ADDR_WIDTH-1:0] idx_inc_d;
    logic [DATA_WIDTH-1:0] vnew_d;

    // Count field from address 0, clamped so idx never leaves the memory.
    assign count_d   = (mem_q[ADDR_WIDTH-1:0] > MAX_IDX) ? MAX_IDX : mem_q[ADDR_WIDTH-1:0];
    assign idx_inc_d = idx_q + 1'b1;

    for (genvar g = 0; g < 3; g++) begin : g_axis
        velocity_axis_update #(
            .COMP_WIDTH (COMP_WIDTH),
            .DT_M       (DT_M),
            .DT_SHIFT   (DT_SHIFT)
        ) u_axis (
            .v_i (vel_q  [g*COMP_WIDTH +: COMP_WIDTH]),
            .f_i (force_q[g*COMP_WIDTH +: COMP_WIDTH]),
            .v_o (vnew_d [g*COMP_WIDTH +: COMP_WIDTH])
        );
    end

    // All outputs are registered: each one is set on the transition into the
    // state in which it must be visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            count_q       <= '0;
            vel_q         <= '0;
            force_q       <= '0;
            mem_data_q    <= '0;
            mem_address_q <= '0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            force_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            force_ready_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q       <= RD_CNT;
                        mem_address_q <= '0;
                        mem_rden_q    <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                RD_CNT: begin
                    state_q <= WAIT_CNT;
                end
                WAIT_CNT: begin
                    count_q <= count_d;
                    if (count_d == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q       <= RD_VEL;
                        idx_q         <= ADDR_WIDTH'(1);
                        mem_address_q <= ADDR_WIDTH'(1);
                        mem_rden_q    <= 1'b1;
                    end
                end
                RD_VEL: begin
                    state_q <= WAIT_VEL;
                end
                WAIT_VEL: begin
                    vel_q         <= mem_q;
                    state_q       <= WAIT_F;
                    force_ready_q <= 1'b1;
                end
                WAIT_F: begin
                    if (force_valid && force_ready_q) begin
                        force_q <= force_data;
                        state_q <= COMPUTE;
                    end else begin
                        force_ready_q <= 1'b1;
                    end
                end
                // ---- stage boundary: v' registered into the write-data port
                COMPUTE: begin
                    mem_data_q    <= vnew_d;
                    mem_address_q <= idx_q;
                    mem_wren_q    <= 1'b1;
                    state_q       <= WRITE;
                end
                WRITE: begin
                    if (idx_q == count_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q         <= idx_inc_d;
                        mem_address_q <= idx_inc_d;
                        mem_rden_q    <= 1'b1;
                        state_q       <= RD_VEL;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign force_ready    = force_ready_q;
    assign mem_address    = mem_address_q;
    assign mem_data       = mem_data_q;
    assign mem_rden       = mem_rden_q;
    assign mem_wren       = mem_wren_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign particle_count = count_q;

endmodule

// File: tb/tb_velocity_update_ctrl.sv
module tb_velocity_update_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        force_valid;
    logic        force_ready;
    logic [95:0] force_data;
    logic [7:0]  mem_address;
    logic [95:0] mem_data;
    logic        mem_rden;
    logic        mem_wren;
    logic [95:0] mem_q;
    logic        busy;
    logic        done;
    logic [7:0]  particle_count;

    velocity_update_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .force_valid    (force_valid),
        .force_ready    (force_ready),
        .force_data     (force_data),
        .mem_address    (mem_address),
        .mem_data       (mem_data),
        .mem_rden       (mem_rden),
        .mem_wren       (mem_wren),
        .mem_q          (mem_q),
        .busy           (busy),
        .done           (done),
        .particle_count (particle_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Velocity memory model with a bench-side preload port.
    logic [95:0] mem [256];
    logic [95:0] ftab [256];
    logic [7:0]  wr_log [$];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [95:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (mem_wren) begin
            mem[mem_address] <= mem_data;
            wr_log.push_back(mem_address);
        end
        if (mem_rden) mem_q <= mem[mem_address];
    end

    int prot_err;
    initial prot_err = 0;
    always @(negedge clk) begin
        if (!rst && ((mem_rden && mem_wren) || (mem_wren && mem_address == 8'd0) ||
                     (force_ready && (mem_rden || mem_wren)))) begin
            prot_err <= prot_err + 1;
            $display("FAIL port_rule at %0t: rden=%0b wren=%0b addr=%0d ready=%0b",
                     $time, mem_rden, mem_wren, mem_address, force_ready);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int vec_cnt;
    int err_cnt;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic load(input int a, input logic [95:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 8'(a);
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Runs one pass. k counts cycles after the edge that samples start
    // (k=1 is RD_CNT). Force words come from ftab indexed by the address held
    // during WAIT_F; valid is held low for stall_cycles WAIT_F cycles of
    // particle stall_addr. abort_addr>0 raises rst in that particle's WAIT_F.
    task automatic run_pass(input int stall_addr, input int stall_cycles,
                            input int abort_addr, input int extra_k, input int max_k,
                            output int done_k, output int done_pulses,
                            output int busy_after, output int wr_k,
                            output int rd_cnt, output int stall_act,
                            output bit aborted);
        int k;
        int stall_left;
        bit fin;
        done_k = -1; done_pulses = 0; busy_after = -1; wr_k = -1;
        rd_cnt = 0; stall_act = 0; aborted = 1'b0; fin = 1'b0;
        stall_left = stall_cycles;
        @(negedge clk);
        start = 1'b1;
        force_valid = 1'b0;
        @(negedge clk);
        k = 1;
        while (!fin) begin
            start = (k == extra_k);
            if (abort_addr > 0 && force_ready && int'(mem_address) == abort_addr) begin
                rst = 1'b1;
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                if (done) begin
                    done_pulses++;
                    if (done_k < 0) done_k = k;
                end
                if (mem_wren) wr_k = k;
                if (mem_rden) rd_cnt++;
                force_data = ftab[mem_address];
                if (force_ready && int'(mem_address) == stall_addr && stall_left > 0) begin
                    force_valid = 1'b0;
                    stall_left--;
                    if (mem_rden || mem_wren) stall_act++;
                end else begin
                    force_valid = 1'b1;
                end
                if (done_k >= 0 && k == done_k + 1) begin
                    busy_after = int'(busy);
                    fin = 1'b1;
                end else if (k >= max_k) begin
                    fin = 1'b1;
                end else begin
                    @(negedge clk);
                    k++;
                end
            end
        end
        start = 1'b0;
        force_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] v;
        logic [31:0] f;
        logic [31:0] exp_wrap;
        logic [31:0] exp_sat;
    } vec_t;

    vec_t vt [12];

    function automatic logic [31:0] expv(input int i);
`ifdef VELOCITY_SAT_EN
        return vt[i].exp_sat;
`else
        return vt[i].exp_wrap;
`endif
    endfunction

    int dk, dp, ba, wk, rc, sa, q0, bad, mx, mn;
    bit ab;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        start = 1'b0;
        force_valid = 1'b0;
        force_data = '0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        for (int i = 0; i < 256; i++) ftab[i] = '0;

        // scaled = (f * 0x8000) >>> 16 = f >>> 1
        vt[0]  = '{32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 32'h0002_0000};
        vt[1]  = '{32'h7FFF_0000, 32'h0002_0000, 32'h8000_0000, 32'h7FFF_FFFF};
        vt[2]  = '{32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFE_0000, 32'hFFFE_0000};
        vt[3]  = '{32'h8000_0000, 32'hFFFE_0000, 32'h7FFF_0000, 32'h8000_0000};
        vt[4]  = '{32'h0000_0000, 32'h0000_0003, 32'h0000_0001, 32'h0000_0001};
        vt[5]  = '{32'h0000_0000, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        vt[6]  = '{32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
        vt[7]  = '{32'h0000_1000, 32'h0000_0001, 32'h0000_1000, 32'h0000_1000};
        vt[8]  = '{32'h7FFF_FFFF, 32'h0000_0002, 32'h8000_0000, 32'h7FFF_FFFF};
        vt[9]  = '{32'h8000_0001, 32'hFFFF_FFFC, 32'h7FFF_FFFF, 32'h8000_0000};
        vt[10] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000};
        vt[11] = '{32'h0010_0000, 32'h7FFF_FFFF, 32'h400F_FFFF, 32'h400F_FFFF};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", 96'({busy, done, force_ready, mem_rden, mem_wren, mem_address, particle_count}), 96'(0));
        chk("reset_mem_data", mem_data, 96'(0));
        rst = 1'b0;

        // Single particle, with a start pulse while busy
        load(0, 96'd1);
        load(1, {32'h0, 32'h0, 32'h0001_0000});
        ftab[1] = {32'h0, 32'h0, 32'h0002_0000};
        q0 = wr_log.size();
        run_pass(0, 0, 0, 4, 50, dk, dp, ba, wk, rc, sa, ab);
        chki("single_done_k", dk, 8);
        chki("single_write_k", wk, 7);
        chki("single_done_pulses", dp, 1);
        chki("single_busy_after_done", ba, 0);
        chki("single_count", int'(particle_count), 1);
        chki("single_writes", wr_log.size() - q0, 1);
        chk("single_vx", mem[1], {32'h0, 32'h0, 32'h0002_0000});
        repeat (3) @(negedge clk);
        chki("busy_start_ignored", int'(busy), 0);

        // Empty cell
        load(0, 96'd0);
        q0 = wr_log.size();
        run_pass(0, 0, 0, 0, 50, dk, dp, ba, wk, rc, sa, ab);
        chki("empty_done_k", dk, 3);
        chki("empty_reads", rc, 1);
        chki("empty_writes", wr_log.size() - q0, 0);
        chki("empty_count", int'(particle_count), 0);

        // Table-driven arithmetic: 4 particles x 3 components
        load(0, 96'd4);
        for (int p = 1; p <= 4; p++) begin
            load(p, {vt[3*p-1].v, vt[3*p-2].v, vt[3*p-3].v});
            ftab[p] = {vt[3*p-1].f, vt[3*p-2].f, vt[3*p-3].f};
        end
        run_pass(0, 0, 0, 0, 100, dk, dp, ba, wk, rc, sa, ab);
        chki("table_done_k", dk, 23);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("table_vec%0d", i), 96'(mem[i/3+1][(i%3)*32 +: 32]), 96'(expv(i)));
        end

        // Force stall of 10 cycles on particle 2 of 3
        load(0, 96'd3);
        for (int p = 1; p <= 3; p++) begin
            load(p, {32'h0, 32'h0, 32'(p) << 16});
            ftab[p] = {32'h0, 32'h0, 32'h0002_0000};
        end
        q0 = wr_log.size();
        run_pass(2, 10, 0, 0, 100, dk, dp, ba, wk, rc, sa, ab);
        chki("stall_done_k", dk, 28);
        chki("stall_mem_activity", sa, 0);
        chki("stall_writes", wr_log.size() - q0, 3);
        bad = 0;
        for (int i = q0; i < wr_log.size(); i++) if (int'(wr_log[i]) != i - q0 + 1) bad++;
        chki("stall_write_order", bad, 0);
        chk("stall_p3", mem[3], {32'h0, 32'h0, 32'h0004_0000});

        // Reset during WAIT_F of particle 2 of 4
        load(0, 96'd4);
        for (int p = 1; p <= 4; p++) begin
            load(p, {32'h0, 32'h0, 32'(p) << 16});
            ftab[p] = {32'h0, 32'h0, 32'h0002_0000};
        end
        run_pass(0, 0, 2, 0, 100, dk, dp, ba, wk, rc, sa, ab);
        chki("abort_reached", int'(ab), 1);
        #1;
        chk("abort_ctrl_zero", 96'({busy, done, force_ready, mem_rden, mem_wren, mem_address, particle_count}), 96'(0));
        chk("abort_data_zero", mem_data, 96'(0));
        @(negedge clk);
        rst = 1'b0;
        chk("abort_p1_updated", mem[1], {32'h0, 32'h0, 32'h0002_0000});
        chk("abort_p2_kept", mem[2], {32'h0, 32'h0, 32'h0002_0000});
        chk("abort_p3_kept", mem[3], {32'h0, 32'h0, 32'h0003_0000});
        chk("abort_p4_kept", mem[4], {32'h0, 32'h0, 32'h0004_0000});
        run_pass(0, 0, 0, 0, 100, dk, dp, ba, wk, rc, sa, ab);
        chki("rerun_done_k", dk, 23);
        chk("rerun_p1", mem[1], {32'h0, 32'h0, 32'h0003_0000});
        chk("rerun_p4", mem[4], {32'h0, 32'h0, 32'h0005_0000});

        // Count clamp: 0xFF -> 219; upper bits of word 0 are not part of the count
        load(0, 96'h0000_0000_0000_0000_0000_12FF);
        for (int p = 1; p < 256; p++) ftab[p] = '0;
        q0 = wr_log.size();
        run_pass(0, 0, 0, 0, 1200, dk, dp, ba, wk, rc, sa, ab);
        chki("clamp_count", int'(particle_count), 219);
        chki("clamp_done_k", dk, 1098);
        chki("clamp_writes", wr_log.size() - q0, 219);
        mx = 0;
        mn = 255;
        for (int i = q0; i < wr_log.size(); i++) begin
            if (int'(wr_log[i]) > mx) mx = int'(wr_log[i]);
            if (int'(wr_log[i]) < mn) mn = int'(wr_log[i]);
        end
        chki("clamp_max_addr", mx, 219);
        chki("clamp_min_addr", mn, 1);

        @(negedge clk);
        chki("port_rules", prot_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/velocity_update_ctrl.md
Name: velocity_update_ctrl

Overview:
- Motion-update sequencer that sits directly upstream of one cell's velocity memory and drives its single RAM port.
- Per cell pass:
  - reads the particle count from address 0;
  - for each particle: reads {vz,vy,vx}, accepts that particle's accumulated force {fz,fy,fx} over a valid/ready handshake, computes v' = v + ((f*DT_M) >>> DT_SHIFT) per component, and writes v' back to the same address.
- One instance per cell; started by the cell-level motion-update controller.

Parameters:
- DATA_WIDTH, 96, packed {z,y,x} word width; matches the velocity memory word.
- COMP_WIDTH, 32, signed fixed-point component width (Q16.16).
- ADDR_WIDTH, 8, velocity memory address width.
- PARTICLE_NUM, 220, memory depth; the largest usable particle index is PARTICLE_NUM-1.
- DT_M, 32'h0000_8000, signed Q16.16 constant dt/m.
- DT_SHIFT, 16, right arithmetic shift applied to each product.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a cell pass; ignored unless in IDLE
- force_valid  in  1  force word available
- force_ready  out  1  block accepts a force word
- force_data  in  DATA_WIDTH  {fz,fy,fx}, signed Q16.16
- mem_address  out  ADDR_WIDTH  velocity memory address
- mem_data  out  DATA_WIDTH  write data {vz',vy',vx'}
- mem_rden  out  1  memory read enable
- mem_wren  out  1  memory write enable
- mem_q  in  DATA_WIDTH  memory read data; valid 1 cycle after mem_rden
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse at the end of a pass
- particle_count  out  ADDR_WIDTH  count latched from address 0

Behaviour:
- Reset: every output, the FSM, the particle index and all capture registers go to 0; the FSM returns to IDLE.
- Reset mid-pass: the pass aborts immediately. Particles already written stay updated; there is no rollback.
- FSM transitions:
  - IDLE -> RD_CNT on start.
  - RD_CNT: drive address 0 with mem_rden=1 -> WAIT_CNT.
  - WAIT_CNT: latch mem_q[ADDR_WIDTH-1:0] into particle_count, clamped to PARTICLE_NUM-1. If the count is 0 -> DONE; otherwise set idx=1 -> RD_VEL.
  - RD_VEL: address=idx, mem_rden=1 -> WAIT_VEL.
  - WAIT_VEL: capture mem_q as v -> WAIT_F.
  - WAIT_F: force_ready=1. On force_valid&&force_ready, capture force_data -> COMPUTE. Stay in WAIT_F while force_valid is low.
  - COMPUTE: register v' (one pipeline stage) -> WRITE.
  - WRITE: address=idx, mem_data=v', mem_wren=1. If idx==particle_count -> DONE; otherwise idx+1 -> RD_VEL.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Port rules:
  - mem_rden and mem_wren are never high in the same cycle.
  - mem_wren is only asserted in WRITE.
  - Address 0 is never written.
  - force_ready is high only in WAIT_F.
- Arithmetic, per component:
  - prod = signed(f) * signed(DT_M), 2*COMP_WIDTH bits.
  - scaled = prod >>> DT_SHIFT, truncated to COMP_WIDTH.
  - sum = v + scaled, with overflow handled per the Optional Feature.
- Throughput: at best 5 cycles per particle (force_valid already high on entry to WAIT_F). Total best-case pass = 3 + 5*N cycles including DONE.
- start pulses while busy are ignored.

Optional Feature:
- Macro: VELOCITY_SAT_EN.
- Defined: each component sum saturates to [0x8000_0000, 0x7FFF_FFFF].
- Undefined: each sum wraps modulo 2^32.

Decomposition:
- Shared package velocity_update_pkg holds:
  - width constants COMP_WIDTH and DATA_WIDTH;
  - the FSM state encoding (IDLE, RD_CNT, WAIT_CNT, RD_VEL, WAIT_VEL, WAIT_F, COMPUTE, WRITE, DONE);
  - default DT_M and DT_SHIFT.
- Sub-module velocity_axis_update: purely combinational per-component multiply-shift-add with the saturation option. Instantiated 3 times; the result register lives in the parent.

Test Plan:
- Single particle: count=1, v_x=0x0001_0000, f_x=0x0002_0000, DT_M=0x8000 -> write to address 1 with vx'=0x0002_0000; done pulses 1 cycle later; busy drops with done.
- Empty cell: count=0 -> no read of address 1, mem_wren never asserted, done exactly 3 cycles after start.
- Force stall: count=3, force_valid held low 10 cycles on particle 2 -> FSM holds in WAIT_F with no memory activity; addresses 1, 2 and 3 each written once, in that order.
- Overflow: v_x=0x7FFF_0000, f_x=0x0002_0000 -> vx'=0x7FFF_FFFF with VELOCITY_SAT_EN defined, 0x8000_0000 without it. Negative case: v=0xFFFF_0000, f=0xFFFE_0000 -> 0xFFFE_0000.
- Reset mid-pass: assert rst during WAIT_F of particle 2 of 4 -> outputs 0 immediately; address 1 keeps its updated value, addresses 2-4 are unchanged; a new start then runs a full pass.
- Protocol checks: a start pulse while busy has no effect; assertion that mem_rden&&mem_wren is never true; count field 0xFF with PARTICLE_NUM=220 clamps to 219.
